// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the response-handshake ALU.
package alu_pkg;

    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_SUB     = 3'b001;
    localparam logic [2:0] OP_MUL     = 3'b010;
    localparam logic [2:0] OP_ILLEGAL = 3'b011;
    localparam logic [2:0] OP_AND     = 3'b100;
    localparam logic [2:0] OP_OR      = 3'b101;
    localparam logic [2:0] OP_SHL     = 3'b110;
    localparam logic [2:0] OP_SHR     = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic logic is_mul(input logic [2:0] op);
        return op == OP_MUL;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned iterative shift-add multiplier: one bit of b per cycle, W cycles after start.
module alu_mul_seq #(
    parameter int unsigned W = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int unsigned CW = $clog2(W + 1);

    logic           busy_q;
    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] mcand_q;
    logic [W-1:0]   mplier_q;
    logic [CW-1:0]  cnt_q;

    // product already folds in the step being taken, so it is final while done is high
    assign product = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done    = busy_q && (cnt_q == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            acc_q    <= '0;
            mcand_q  <= {{W{1'b0}}, a};
            mplier_q <= b;
            cnt_q    <= CW'(W);
        end else if (busy_q) begin
            acc_q    <= product;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_resp.sv
// ALU with valid/ready request and response handshakes; multiply runs on a sequential multiplier.
module alu_resp
    import alu_pkg::*;
#(
    parameter int unsigned W = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [2:0]     sel,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic [2*W-1:0] y,
    output logic           err
);

    state_e         state_q;
    logic [2*W-1:0] ext_a;
    logic [2*W-1:0] ext_b;
    logic [2*W-1:0] alu_res;
    logic           mul_start;
    logic           mul_done;
    logic [2*W-1:0] mul_product;

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StDone);
    assign ext_a      = {{W{1'b0}}, a};
    assign ext_b      = {{W{1'b0}}, b};
    assign mul_start  = req_valid && (state_q == StIdle) && is_mul(sel);

    always_comb begin
        alu_res = '0;
        case (sel)
            OP_ADD:  alu_res = ext_a + ext_b;
            OP_SUB:  alu_res = ext_a - ext_b;
            OP_AND:  alu_res = ext_a & ext_b;
            OP_OR:   alu_res = ext_a | ext_b;
            OP_SHL:  alu_res = ext_a << 1;
            OP_SHR:  alu_res = ext_a >> 1;
            default: alu_res = '0;
        endcase
    end

    alu_mul_seq #(
        .W(W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            y       <= '0;
            err     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        if (is_mul(sel)) begin
                            state_q <= StBusy;
                        end else begin
                            state_q <= StDone;
                            y       <= alu_res;
                            err     <= (sel == OP_ILLEGAL);
                        end
                    end
                end
                StBusy: begin
                    if (mul_done) begin
                        state_q <= StDone;
                        y       <= mul_product;
                        err     <= 1'b0;
                    end
                end
                StDone: begin
                    if (resp_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_resp.sv
// Randomised and directed bench for alu_resp against an arithmetic reference model.
module tb_alu_resp;

    localparam int unsigned W = 10;
    localparam logic [63:0] MASK = (64'd1 << (2 * W)) - 64'd1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid = 1'b0;
    logic           resp_ready = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic [2:0]     sel = '0;
    logic           req_ready;
    logic           resp_valid;
    logic [2*W-1:0] y;
    logic           err;

    int n_checks = 0;
    int n_errors = 0;

    alu_resp #(
        .W(W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .a          (a),
        .b          (b),
        .sel        (sel),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .y          (y),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_y(input logic [2:0] op, input logic [63:0] x,
                                          input logic [63:0] z);
        case (op)
            3'd0:    return (x + z) & MASK;
            3'd1:    return (x - z) & MASK;
            3'd2:    return x * z;
            3'd3:    return 64'd0;
            3'd4:    return x & z;
            3'd5:    return x | z;
            3'd6:    return x * 2;
            default: return x / 2;
        endcase
    endfunction

    // One full transaction; inputs are scrambled while the op is in flight and
    // a request is held on the bus during the backpressure window.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [2:0] ts,
                          input int hold);
        int lat;
        logic [63:0] exp_y;
        exp_y = ref_y(ts, 64'(ta), 64'(tb));
        @(negedge clk);
        check_eq("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        a = ta;
        b = tb;
        sel = ts;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 50) begin
            a = W'($urandom);
            b = W'($urandom);
            sel = 3'($urandom);
            req_valid = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        check_eq("resp_valid", 64'(resp_valid), 64'd1);
        check_eq("latency", 64'(lat), (ts == 3'd2) ? 64'(W + 1) : 64'd1);
        check_eq("y", 64'(y), exp_y);
        check_eq("err", 64'(err), (ts == 3'd3) ? 64'd1 : 64'd0);
        check_eq("req_ready_done", 64'(req_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
            sel = 3'($urandom);
            @(negedge clk);
            check_eq("hold_y", 64'(y), exp_y);
            check_eq("hold_resp_valid", 64'(resp_valid), 64'd1);
            check_eq("hold_req_ready", 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check_eq("post_resp_valid", 64'(resp_valid), 64'd0);
        check_eq("post_req_ready", 64'(req_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int late_resp;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_req_ready", 64'(req_ready), 64'd1);
        check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_eq("rst_y", 64'(y), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        rst = 1'b0;

        run_op(10'd31, 10'd3, 3'b000, 0);
        run_op(10'd20, 10'd4, 3'b010, 5);
        run_op(10'd1023, 10'd1023, 3'b010, 0);
        run_op(10'd5, 10'd10, 3'b001, 1);
        run_op(10'd960, 10'd0, 3'b111, 0);
        run_op(10'd1023, 10'd0, 3'b110, 0);
        run_op(10'h2AA, 10'h1F5, 3'b100, 0);
        run_op(10'h2AA, 10'h155, 3'b101, 0);
        run_op(10'd7, 10'd9, 3'b011, 2);
        run_op(10'd31, 10'd3, 3'b000, 0);

        // Reset four cycles into a multiply; y still holds the previous result.
        @(negedge clk);
        req_valid = 1'b1;
        a = 10'd20;
        b = 10'd4;
        sel = 3'b010;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrst_req_ready", 64'(req_ready), 64'd1);
        check_eq("midrst_resp_valid", 64'(resp_valid), 64'd0);
        check_eq("midrst_y", 64'(y), 64'd0);
        check_eq("midrst_err", 64'(err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        late_resp = 0;
        repeat (15) begin
            @(negedge clk);
            if (resp_valid) late_resp++;
        end
        check_eq("no_resp_after_rst", 64'(late_resp), 64'd0);
        check_eq("idle_after_rst", 64'(req_ready), 64'd1);

        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 3'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
